// File: rtl/key_pkg.sv
// Shared key encodings and press-sequence state type, also used by the key-detect block.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_BNC = 3'd1,
    HOLD  = 3'd2,
    R_BNC = 3'd3,
    GAP   = 3'd4
  } key_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_press_gen_if.sv
// Request/status bundle between a key-press requester and the key waveform generator.
interface key_press_gen_if #(
  parameter int CNT_W = 20
);
  logic             start;
  logic [CNT_W-1:0] press_len;
  logic             bounce_en;
  logic             key_out;
  logic             busy;
  logic             done;

  modport master (output start, press_len, bounce_en, input key_out, busy, done);
  modport slave  (input start, press_len, bounce_en, output key_out, busy, done);
endinterface

// File: rtl/key_press_gen_cycle_timer.sv
// Loadable down-counter for phase timing; holds at zero and flags expiry while there.
module key_press_gen_cycle_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/key_press_gen.sv
// Emulated active-low key: optional press bounce, held-low phase, optional release bounce, idle gap.
module key_press_gen
  import key_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int BOUNCE_PERIOD = 4,
  parameter int BOUNCE_SEGS   = 4,
  parameter int GAP_CYCLES    = 16
) (
  input logic            sys_clk,
  input logic            rst_n,
  key_press_gen_if.slave kif
);

  localparam logic [CNT_W-1:0] BNC_LEN  = CNT_W'(BOUNCE_SEGS * BOUNCE_PERIOD);
  localparam logic [CNT_W-1:0] BNC_LAST = BNC_LEN - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(BOUNCE_PERIOD);

  if (BOUNCE_PERIOD < 1 || BOUNCE_SEGS < 1 || GAP_CYCLES < 1 ||
      (longint'(BOUNCE_SEGS) * longint'(BOUNCE_PERIOD)) > (longint'(1) << CNT_W) ||
      longint'(GAP_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("key_press_gen: bounce/gap lengths must be >=1 and fit CNT_W");
  end

  key_state_t       state;
  logic [CNT_W-1:0] len_q;
  logic             bnc_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expired;

  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  // Parity of the bounce segment the next cycle falls into, from the remaining phase count.
  function automatic logic seg_odd_next(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt_elapsed;
    nxt_elapsed = BNC_LEN - cnt;
    return 1'(nxt_elapsed / PERIOD);
  endfunction

  key_press_gen_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:  if (kif.start) begin
               tmr_load = 1'b1;
               tmr_val  = kif.bounce_en ? BNC_LAST : eff_len(kif.press_len) - CNT_W'(1);
             end
      P_BNC: if (tmr_expired) begin tmr_load = 1'b1; tmr_val = len_q - CNT_W'(1); end
      HOLD:  if (tmr_expired) begin tmr_load = 1'b1; tmr_val = bnc_q ? BNC_LAST : GAP_LAST; end
      R_BNC: if (tmr_expired) begin tmr_load = 1'b1; tmr_val = GAP_LAST; end
      GAP:   if (tmr_expired) begin tmr_load = 1'b1; tmr_val = '0; end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (state == IDLE && kif.start) begin
      len_q <= eff_len(kif.press_len);
      bnc_q <= kif.bounce_en;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      kif.key_out <= KEY_RELEASED;
      kif.busy    <= 1'b0;
      kif.done    <= 1'b0;
    end else begin
      kif.done <= 1'b0;
      case (state)
        IDLE: if (kif.start) begin
          state       <= kif.bounce_en ? P_BNC : HOLD;
          kif.key_out <= KEY_PRESSED;
          kif.busy    <= 1'b1;
        end
        P_BNC: if (tmr_expired) begin
          state       <= HOLD;
          kif.key_out <= KEY_PRESSED;
        end else begin
          kif.key_out <= seg_odd_next(tmr_count) ? KEY_RELEASED : KEY_PRESSED;
        end
        HOLD: if (tmr_expired) begin
          state       <= bnc_q ? R_BNC : GAP;
          kif.key_out <= KEY_RELEASED;
        end
        R_BNC: if (tmr_expired) begin
          state       <= GAP;
          kif.key_out <= KEY_RELEASED;
        end else begin
          kif.key_out <= seg_odd_next(tmr_count) ? KEY_PRESSED : KEY_RELEASED;
        end
        GAP: if (tmr_expired) begin
          state    <= IDLE;
          kif.busy <= 1'b0;
          kif.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Scoreboard bench: each scenario queues the expected per-cycle key/busy/done and checks it live.
module tb_key_press_gen;

  localparam int CNT_W = 20;
  localparam int P     = 4;
  localparam int S     = 4;
  localparam int G     = 16;

  typedef struct {
    logic key;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  key_press_gen_if #(.CNT_W(CNT_W)) kif ();

  key_press_gen #(
    .CNT_W         (CNT_W),
    .BOUNCE_PERIOD (P),
    .BOUNCE_SEGS   (S),
    .GAP_CYCLES    (G)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .kif     (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic push_e(input logic k, input logic b, input logic d);
    exp_t e;
    e.key = k; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_e(1'b1, 1'b0, 1'b0);
  endtask

  // Expected cycles N+1 .. done cycle for one sequence started at edge N.
  task automatic push_run(input int len, input bit bnc);
    int eff;
    eff = (len == 0) ? 1 : len;
    if (bnc) for (int i = 0; i < S*P; i++) push_e(((i / P) % 2) == 1, 1'b1, 1'b0);
    for (int i = 0; i < eff; i++) push_e(1'b0, 1'b1, 1'b0);
    if (bnc) for (int i = 0; i < S*P; i++) push_e(((i / P) % 2) == 0, 1'b1, 1'b0);
    for (int i = 0; i < G; i++) push_e(1'b1, 1'b1, 1'b0);
    push_e(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0; kif.start = 1'b1; kif.press_len = 5; kif.bounce_en = 1'b0;
    push_idle(6);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin rst_n = 1'b1; kif.start = 1'b0; end
      e = exp_q.pop_front();
      vectors++;
      if (kif.key_out !== e.key || kif.busy !== e.busy || kif.done !== e.done) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got key=%b busy=%b done=%b, want key=%b busy=%b done=%b",
                 k, kif.key_out, kif.busy, kif.done, e.key, e.busy, e.done);
      end
    end
  endtask

  task automatic test_press(input string tag, input int len, input bit bnc);
    exp_t e;
    @(negedge clk);
    kif.start = 1'b1; kif.press_len = CNT_W'(len); kif.bounce_en = bnc;
    push_run(len, bnc);
    push_idle(2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) kif.start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (kif.key_out !== e.key || kif.busy !== e.busy || kif.done !== e.done) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got key=%b busy=%b done=%b, want key=%b busy=%b done=%b",
                 tag, k, kif.key_out, kif.busy, kif.done, e.key, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    kif.start = 1'b1; kif.press_len = 8; kif.bounce_en = 1'b0;
    push_run(8, 1'b0);
    push_run(8, 1'b0);
    push_idle(2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) kif.start = 1'b0;
      if (k == 3) begin kif.start = 1'b1; kif.press_len = 20; kif.bounce_en = 1'b1; end
      if (k == 4) kif.start = 1'b0;
      if (k == 25) begin kif.start = 1'b1; kif.press_len = 8; kif.bounce_en = 1'b0; end
      if (k == 26) kif.start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (kif.key_out !== e.key || kif.busy !== e.busy || kif.done !== e.done) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got key=%b busy=%b done=%b, want key=%b busy=%b done=%b",
                 k, kif.key_out, kif.busy, kif.done, e.key, e.busy, e.done);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    @(negedge clk);
    kif.start = 1'b1; kif.press_len = 8; kif.bounce_en = 1'b0;
    for (int i = 0; i < 4; i++) push_e(1'b0, 1'b1, 1'b0);
    push_idle(26);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) kif.start = 1'b0;
      if (k == 4) rst_n = 1'b0;
      if (k == 6) rst_n = 1'b1;
      e = exp_q.pop_front();
      vectors++;
      if (kif.key_out !== e.key || kif.busy !== e.busy || kif.done !== e.done) begin
        miscompares++;
        $display("FAIL abort cyc %0d: got key=%b busy=%b done=%b, want key=%b busy=%b done=%b",
                 k, kif.key_out, kif.busy, kif.done, e.key, e.busy, e.done);
      end
    end
    @(negedge clk);
    kif.start = 1'b1; kif.press_len = 8; kif.bounce_en = 1'b0;
    push_run(8, 1'b0);
    push_idle(2);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) kif.start = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (kif.key_out !== e.key || kif.busy !== e.busy || kif.done !== e.done) begin
        miscompares++;
        $display("FAIL after_abort cyc %0d: got key=%b busy=%b done=%b, want key=%b busy=%b done=%b",
                 k, kif.key_out, kif.busy, kif.done, e.key, e.busy, e.done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    kif.start = 1'b0;
    kif.press_len = '0;
    kif.bounce_en = 1'b0;
    test_reset();
    test_press("no_bounce", 8, 1'b0);
    test_press("bounce", 8, 1'b1);
    test_press("zero_len", 0, 1'b0);
    test_press("len1_bounce", 1, 1'b1);
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
